// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational ROM,
// and buffers {pc, instr} pairs in a 2-entry FIFO toward decode.
// Redirects flush the FIFO and retarget the PC. Fetch halts once the PC reaches
// IMEM_LIMIT.
// Optional macro FETCH_PERF_CNT_EN adds the perf_fetched and perf_stall counters.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] PC_STEP    = 16'd4,
    parameter int unsigned IMEM_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pc,
    output logic [15:0] out_instr,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall
`endif
);

    typedef enum logic [0:0] {StFetch, StHalt} state_e;

    // Widened by one bit so a limit of 2^16 still compares correctly.
    localparam logic [16:0] LimitExt = 17'(IMEM_LIMIT);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] q0_pc_q, q0_pc_d, q0_instr_q, q0_instr_d;
    logic [15:0] q1_pc_q, q1_pc_d, q1_instr_q, q1_instr_d;
    logic        pop, push, at_limit;

    assign imem_pc   = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_pc    = out_valid ? q0_pc_q : 16'h0000;
    assign out_instr = out_valid ? q0_instr_q : 16'h0000;
    assign halted    = (state_q == StHalt);
    assign pop       = out_valid && out_ready;
    assign at_limit  = ({1'b0, pc_q} >= LimitExt);

    // Next-state: redirect wins, otherwise sequential fetch into the FIFO.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        q0_pc_d    = q0_pc_q;
        q0_instr_d = q0_instr_q;
        q1_pc_d    = q1_pc_q;
        q1_instr_d = q1_instr_q;
        push       = 1'b0;

        if (redirect_valid) begin
            state_d = StFetch;
            pc_d    = redirect_pc & 16'hFFFC;
            count_d = 2'd0;
        end else begin
            if (state_q == StFetch) begin
                if (at_limit) begin
                    state_d = StHalt;
                end else begin
                    // A pop frees a slot in the same cycle, so a full FIFO keeps streaming.
                    push = (count_q != 2'd2) || pop;
                end
            end
            if (push) begin
                pc_d = pc_q + PC_STEP;
            end
            case ({push, pop})
                2'b01: begin
                    q0_pc_d    = q1_pc_q;
                    q0_instr_d = q1_instr_q;
                    count_d    = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        q0_pc_d    = pc_q;
                        q0_instr_d = imem_instr;
                    end else begin
                        q1_pc_d    = pc_q;
                        q1_instr_d = imem_instr;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        q0_pc_d    = pc_q;
                        q0_instr_d = imem_instr;
                    end else begin
                        q0_pc_d    = q1_pc_q;
                        q0_instr_d = q1_instr_q;
                        q1_pc_d    = pc_q;
                        q1_instr_d = imem_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, PC and FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            q0_pc_q    <= 16'h0000;
            q0_instr_q <= 16'h0000;
            q1_pc_q    <= 16'h0000;
            q1_instr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            q0_pc_q    <= q0_pc_d;
            q0_instr_q <= q0_instr_d;
            q1_pc_q    <= q1_pc_d;
            q1_instr_q <= q1_instr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_q, perf_stall_q;
    logic        stall;

    assign stall        = (state_q == StFetch) && (count_q == 2'd2) && !pop;
    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;

    // Saturating event counters; redirects leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 16'h0000;
            perf_stall_q   <= 16'h0000;
        end else begin
            if (push && (perf_fetched_q != 16'hFFFF)) begin
                perf_fetched_q <= perf_fetched_q + 16'd1;
            end
            if (stall && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: distinct word per index.
    function automatic logic [15:0] rom_word(input logic [3:0] idx);
        return 16'hC3A5 ^ {idx, idx, ~idx, idx};
    endfunction

    assign imem_instr = rom_word(imem_pc[5:2]);

    // Reference model: FIFO as a queue, PC as plain arithmetic.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    bit          m_halt;
    int          m_fetched;
    int          m_stall;

    task automatic model_reset();
        mq.delete();
        m_pc      = 16'h0000;
        m_halt    = 1'b0;
        m_fetched = 0;
        m_stall   = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after the falling edge, then compare against the model.
    task automatic drive(input logic rdy, input logic rv, input logic [15:0] rp);
        logic [15:0] e_pc, e_instr;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
        e_pc    = (mq.size() != 0) ? mq[0].pc : 16'h0000;
        e_instr = (mq.size() != 0) ? mq[0].instr : 16'h0000;
        check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        check("out_pc", {16'd0, out_pc}, {16'd0, e_pc});
        check("out_instr", {16'd0, out_instr}, {16'd0, e_instr});
        check("imem_pc", {16'd0, imem_pc}, {16'd0, m_pc});
        check("halted", {31'd0, halted}, {31'd0, m_halt});
    endtask

    // Clock edge: advance the model by the rules, then return to the falling edge.
    task automatic advance();
        bit pop;
        @(posedge clk);
        pop = (mq.size() != 0) && out_ready;
        if (!m_halt && (mq.size() == 2) && !pop) m_stall++;
        if (redirect_valid) begin
            mq.delete();
            m_pc   = redirect_pc & 16'hFFFC;
            m_halt = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_halt) begin
                if (m_pc >= 16'd64) begin
                    m_halt = 1'b1;
                end else if (mq.size() < 2) begin
                    mq.push_back('{pc: m_pc, instr: rom_word(m_pc[5:2])});
                    m_pc = m_pc + 16'd4;
                    m_fetched++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rp;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] eimem;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [15:0] last_pc;
        bit          seen_end;
        logic [15:0] rp;

        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // Stream, 5-cycle backpressure, release, then redirect to 0x0022.
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0004};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0008};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h000C};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h000C};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h000C};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h000C};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h000C};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h0010};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h000C, 16'h0014};
        tbl[10] = '{1'b0, 1'b1, 16'h0022, 1'b1, 16'h0010, 16'h0018};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0020};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 16'h0024};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rdy, tbl[i].rv, tbl[i].rp);
            check("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].ev});
            check("tbl_pc", {16'd0, out_pc}, {16'd0, tbl[i].epc});
            check("tbl_instr", {16'd0, out_instr},
                  {16'd0, tbl[i].ev ? rom_word(tbl[i].epc[5:2]) : 16'h0000});
            check("tbl_imem_pc", {16'd0, imem_pc}, {16'd0, tbl[i].eimem});
            check("tbl_halted", {31'd0, halted}, 32'd0);
            advance();
        end

        // Fill the FIFO, then assert reset between clock edges.
        drive(1'b0, 1'b0, 16'h0000);
        advance();
        drive(1'b0, 1'b0, 16'h0000);
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_imem_pc", {16'd0, imem_pc}, 32'd0);
        check("async_rst_halted", {31'd0, halted}, 32'd0);
        check("async_rst_out_pc", {16'd0, out_pc}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Stream to the end of the ROM and let the FIFO drain.
        last_pc  = 16'hFFFF;
        seen_end = 1'b0;
        for (int i = 0; i < 40 && !seen_end; i++) begin
            drive(1'b1, 1'b0, 16'h0000);
            if (out_valid) last_pc = out_pc;
            if (!out_valid && halted) seen_end = 1'b1;
            else advance();
        end
        check("halt_last_pc", {16'd0, last_pc}, 32'd60);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, out_valid}, 32'd0);
        check("halt_imem_pc", {16'd0, imem_pc}, 32'd64);
        advance();
        drive(1'b0, 1'b1, 16'h0004);
        check("halt_hold", {31'd0, halted}, 32'd1);
        advance();
        drive(1'b1, 1'b0, 16'h0000);
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_imem_pc", {16'd0, imem_pc}, 32'd4);
        advance();
        drive(1'b1, 1'b0, 16'h0000);
        check("resume_valid", {31'd0, out_valid}, 32'd1);
        check("resume_pc", {16'd0, out_pc}, 32'd4);
        check("resume_instr", {16'd0, out_instr}, {16'd0, rom_word(4'd1)});
        advance();

`ifdef FETCH_PERF_CNT_EN
        // 2 fills + 3 full stalls, 8 streaming pushes, then park at the limit.
        do_reset();
        repeat (5) begin
            drive(1'b0, 1'b0, 16'h0000);
            advance();
        end
        repeat (8) begin
            drive(1'b1, 1'b0, 16'h0000);
            advance();
        end
        drive(1'b1, 1'b1, 16'h0040);
        advance();
        drive(1'b1, 1'b0, 16'h0000);
        advance();
        drive(1'b1, 1'b0, 16'h0000);
        check("perf_fetched", {16'd0, perf_fetched}, 32'd10);
        check("perf_stall", {16'd0, perf_stall}, 32'd3);
        advance();
`endif

        // Randomized traffic with occasional redirects (misaligned, past the limit).
        for (int i = 0; i < 1500; i++) begin
            rp = 16'($urandom_range(0, 80));
            if ($urandom_range(0, 9) == 0) rp = 16'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rp);
            advance();
        end
`ifdef FETCH_PERF_CNT_EN
        drive(1'b0, 1'b0, 16'h0000);
        check("rand_perf_fetched", {16'd0, perf_fetched},
              (m_fetched > 65535) ? 32'hFFFF : 32'(m_fetched));
        check("rand_perf_stall", {16'd0, perf_stall},
              (m_stall > 65535) ? 32'hFFFF : 32'(m_stall));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
